rs_chien_forney: RTL and testbench



---
 rtl/rs_chien_forney.sv | 225 ++++++++++++++++++++++
 tb/tb_rs_chien_forney.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_chien_forney.sv
// Reed-Solomon Chien search and Forney back end: streams one error flag/value per symbol after BMA.
// Optional Forney error-value path is compiled in with `define RS_CHIEN_FORNEY_EN.
module rs_chien_forney #(
   parameter int m       = 8,
   parameter int n       = 255,
   parameter int check   = 16,
   parameter int errs    = check / 2,
   parameter int irrpol  = 285,
   parameter bit pLOG_ON = 1'b1
) (
   input  logic         iclk,
   input  logic         ireset,
   input  logic         iloc_poly_val,
   input  logic [m-1:0] iloc_poly   [0:errs],
   input  logic [m-1:0] iomega_poly [1:errs],
   input  logic [m-1:0] iloc_poly_deg,
   input  logic         iloc_failed,
   output logic         ordy,
   output logic         osop,
   output logic         oval,
   output logic         oeop,
   output logic         oerr_flag,
   output logic [m-1:0] oerr_val,
   output logic [m-1:0] oerr_cnt,
   output logic         odecfail
);

   localparam int q  = (1 << m) - 1;
   localparam int off = q - (n - 1);
   localparam int cw  = (n > 1) ? $clog2(n) : 1;
   localparam logic [cw-1:0] last_sym = cw'(n - 1);
   localparam logic [m-1:0]  poly_lo  = m'(irrpol);

   function automatic logic [m-1:0] gf_mul(input logic [m-1:0] a, input logic [m-1:0] b);
      logic [m-1:0] acc, sh;
      acc = '0;
      sh  = a;
      for (int i = 0; i < m; i++) begin
         if (b[i]) acc ^= sh;
         sh = sh[m-1] ? ((sh << 1) ^ poly_lo) : (sh << 1);
      end
      return acc;
   endfunction

   // alpha^e by square-and-multiply; e is reduced mod 2^m-1 first
   function automatic logic [m-1:0] gf_pow_alpha(input int e);
      logic [m-1:0] r, b;
      int           e2;
      e2 = e % q;
      r  = m'(1);
      b  = m'(2);
      for (int i = 0; i < m; i++) begin
         if (((e2 >> i) & 1) != 0) r = gf_mul(r, b);
         b = gf_mul(b, b);
      end
      return r;
   endfunction

   typedef enum logic [1:0] {IDLE, LOAD, SEARCH, FLUSH} state_t;

   state_t         state;
   logic [cw-1:0]  sym_cnt;
   logic [m-1:0]   root_cnt, root_next;
   logic [m-1:0]   deg_r;
   logic           failed_r;
   logic           dzero, dzero_next;
   logic [m-1:0]   lam_r   [0:errs];
   logic [m-1:0]   pre_w   [0:errs];
   logic [m-1:0]   step_w  [0:errs];
   logic [m-1:0]   lam_sum;
   logic           root_now;
   logic [m-1:0]   err_val;

   for (genvar j = 0; j <= errs; j++) begin : g_const
      localparam logic [m-1:0] pre_c  = gf_pow_alpha(j * off);
      localparam logic [m-1:0] step_c = gf_pow_alpha(j);
      assign pre_w[j]  = pre_c;
      assign step_w[j] = step_c;
   end

   // Raw coefficients land at accept; LOAD applies the shortening offset, SEARCH steps x by alpha.
   always_ff @(posedge iclk) begin
      for (int j = 0; j <= errs; j++) begin
         case (state)
            IDLE:    if (iloc_poly_val) lam_r[j] <= iloc_poly[j];
            LOAD:    lam_r[j] <= gf_mul(lam_r[j], pre_w[j]);
            SEARCH:  lam_r[j] <= gf_mul(lam_r[j], step_w[j]);
            default: lam_r[j] <= lam_r[j];
         endcase
      end
   end

   always_comb begin
      lam_sum = '0;
      for (int j = 0; j <= errs; j++) lam_sum ^= lam_r[j];
   end

   assign root_now  = (lam_sum == '0);
   assign root_next = (root_now && root_cnt != '1) ? root_cnt + 1'b1 : root_cnt;

`ifdef RS_CHIEN_FORNEY_EN
   function automatic logic [m-1:0] gf_inv(input logic [m-1:0] a);
      logic [m-1:0] r, sq;
      r  = m'(1);
      sq = a;
      for (int i = 1; i < m; i++) begin
         sq = gf_mul(sq, sq);
         r  = gf_mul(r, sq);
      end
      return r;
   endfunction

   logic [m-1:0] om_r    [1:errs];
   logic [m-1:0] inv_rom [0:q];
   logic [m-1:0] om_sum, lodd_sum, lodd_inv;

   for (genvar i = 0; i <= q; i++) begin : g_inv
      localparam logic [m-1:0] inv_c = gf_inv(m'(i));
      assign inv_rom[i] = inv_c;
   end

   always_ff @(posedge iclk) begin
      for (int j = 1; j <= errs; j++) begin
         case (state)
            IDLE:    if (iloc_poly_val) om_r[j] <= iomega_poly[j];
            LOAD:    om_r[j] <= gf_mul(om_r[j], pre_w[j]);
            SEARCH:  om_r[j] <= gf_mul(om_r[j], step_w[j]);
            default: om_r[j] <= om_r[j];
         endcase
      end
   end

   // Lambda_odd = x*Lambda'(x) in characteristic 2
   always_comb begin
      om_sum   = '0;
      lodd_sum = '0;
      for (int j = 1; j <= errs; j++) begin
         om_sum ^= om_r[j];
         if (j % 2 == 1) lodd_sum ^= lam_r[j];
      end
   end

   assign lodd_inv   = inv_rom[lodd_sum];
   assign err_val    = gf_mul(om_sum, lodd_inv);
   assign dzero_next = dzero | (root_now & (lodd_sum == '0));
`else
   logic omega_unused;
   always_comb begin
      omega_unused = dzero;
      for (int j = 1; j <= errs; j++) omega_unused ^= ^iomega_poly[j];
   end

   assign err_val    = '0;
   assign dzero_next = 1'b0;
`endif

   always_ff @(posedge iclk) begin
      if (ireset) begin
         state     <= IDLE;
         ordy      <= 1'b1;
         osop      <= 1'b0;
         oval      <= 1'b0;
         oeop      <= 1'b0;
         oerr_flag <= 1'b0;
         oerr_val  <= '0;
         oerr_cnt  <= '0;
         odecfail  <= 1'b0;
         sym_cnt   <= '0;
         root_cnt  <= '0;
         deg_r     <= '0;
         failed_r  <= 1'b0;
         dzero     <= 1'b0;
      end else begin
         osop      <= 1'b0;
         oval      <= 1'b0;
         oeop      <= 1'b0;
         oerr_flag <= 1'b0;
         oerr_val  <= '0;
         oerr_cnt  <= '0;
         odecfail  <= 1'b0;
         case (state)
            IDLE: begin
               if (iloc_poly_val) begin
                  state    <= LOAD;
                  ordy     <= 1'b0;
                  deg_r    <= iloc_poly_deg;
                  failed_r <= iloc_failed;
               end
            end
            LOAD: begin
               state    <= SEARCH;
               sym_cnt  <= '0;
               root_cnt <= '0;
               dzero    <= 1'b0;
            end
            SEARCH: begin
               oval      <= 1'b1;
               osop      <= (sym_cnt == '0);
               oerr_flag <= root_now && !failed_r;
               oerr_val  <= (root_now && !failed_r) ? err_val : '0;
               root_cnt  <= root_next;
               dzero     <= dzero_next;
               sym_cnt   <= sym_cnt + 1'b1;
               if (sym_cnt == last_sym) begin
                  oeop     <= 1'b1;
                  oerr_cnt <= root_next;
                  odecfail <= failed_r | (root_next != deg_r) | dzero_next;
                  state    <= FLUSH;
               end
            end
            FLUSH: begin
               state <= IDLE;
               ordy  <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   if (pLOG_ON) begin : g_chk
      a_val_clean: assert property (@(posedge iclk) !oerr_flag |-> oerr_val == '0);
      a_eop_in_stream: assert property (@(posedge iclk) oeop |-> oval);
   end

endmodule

// File: tb/tb_rs_chien_forney.sv
// Self-checking bench for rs_chien_forney: RS(255,239) with a behavioural GF(256) model.
`timescale 1ns/1ps
module tb_rs_chien_forney;
   localparam int M = 8, N = 255, ERRS = 8;
`ifdef RS_CHIEN_FORNEY_EN
   localparam bit FEN = 1'b1;
`else
   localparam bit FEN = 1'b0;
`endif

   logic         iclk = 1'b0, ireset = 1'b1, iloc_poly_val = 1'b0, iloc_failed = 1'b0;
   logic [M-1:0] iloc_poly   [0:ERRS];
   logic [M-1:0] iomega_poly [1:ERRS];
   logic [M-1:0] iloc_poly_deg = '0;
   logic         ordy, osop, oval, oeop, oerr_flag, odecfail;
   logic [M-1:0] oerr_val, oerr_cnt;

   always #5 iclk = ~iclk;

   rs_chien_forney #(.m(M), .n(N), .check(16), .irrpol(285), .pLOG_ON(1'b1)) dut (
      .iclk(iclk), .ireset(ireset), .iloc_poly_val(iloc_poly_val), .iloc_poly(iloc_poly),
      .iomega_poly(iomega_poly), .iloc_poly_deg(iloc_poly_deg), .iloc_failed(iloc_failed),
      .ordy(ordy), .osop(osop), .oval(oval), .oeop(oeop), .oerr_flag(oerr_flag),
      .oerr_val(oerr_val), .oerr_cnt(oerr_cnt), .odecfail(odecfail));

   int tests = 0, fails = 0;
   int gexp [0:254];
   int glog [0:255];
   int gL [0:ERRS];
   int gO [0:ERRS];

   function automatic int gmul(int a, int b);
      if (a == 0 || b == 0) return 0;
      return gexp[(glog[a] + glog[b]) % 255];
   endfunction
   function automatic int ginv(int a);
      return (a == 0) ? 0 : gexp[(255 - glog[a]) % 255];
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   int cyc = 0, act_A = -1, ecnt = 0;
   bit m_failed = 1'b0, efail = 1'b0, chk_en = 1'b0;
   bit ef [0:N-1];
   int ev [0:N-1];

   task automatic model_load();
      int cnt;
      bit dz;
      cnt = 0;
      dz  = 1'b0;
      for (int s = 0; s < N; s++) begin
         int p, x, xp, lam, lodd, om;
         p = N - 1 - s;
         x = gexp[(255 - p) % 255];
         xp = 1; lam = 0; lodd = 0; om = 0;
         for (int j = 0; j <= ERRS; j++) begin
            int t;
            t = gmul(int'(iloc_poly[j]), xp);
            lam ^= t;
            if (j % 2 == 1) lodd ^= t;
            if (j > 0) om ^= gmul(int'(iomega_poly[j]), xp);
            xp = gmul(xp, x);
         end
         if (lam == 0) begin
            if (cnt < 255) cnt++;
            if (lodd == 0) dz = 1'b1;
         end
         ef[s] = (lam == 0) && !iloc_failed;
         ev[s] = (ef[s] && FEN) ? gmul(om, ginv(lodd)) : 0;
      end
      ecnt     = cnt;
      m_failed = iloc_failed;
      efail    = iloc_failed || (cnt != int'(iloc_poly_deg)) || (FEN && dz);
   endtask

   always @(posedge iclk) begin
      if (ireset) act_A = -1;
      else if (iloc_poly_val && (act_A < 0 || cyc >= act_A + N + 3)) begin
         act_A = cyc;
         model_load();
      end
      cyc = cyc + 1;
   end

   // ---------------- compare + recorder ----------------
   logic [21:0] act_v, exp_v;
   bit inf, eopx;
   int s_i, rec_s = 0, nvals = 0, eop_cnt = 0, eop_fail = 0;
   int sop_q[$], eop_q[$], fs_q[$], fv_q[$];

   always @(negedge iclk) if (chk_en) begin
      inf  = act_A >= 0 && cyc >= act_A + 3 && cyc <= act_A + N + 2;
      s_i  = inf ? cyc - act_A - 3 : 0;
      eopx = inf && s_i == N - 1;
      exp_v = {!(act_A >= 0 && cyc >= act_A + 1 && cyc <= act_A + N + 2), inf, inf && s_i == 0, eopx,
               inf && ef[s_i], inf ? 8'(ev[s_i]) : 8'd0, (eopx && !m_failed) ? 8'(ecnt) : 8'd0, eopx && efail};
      act_v = {ordy, oval, osop, oeop, oerr_flag, oerr_val,
               (eopx && !m_failed) ? oerr_cnt : 8'd0, eopx && odecfail};
      tests++;
      if (act_v !== exp_v) begin
         fails++;
         $display("FAIL stream cyc=%0d got %h expected %h", cyc, act_v, exp_v);
      end
      if (oval) begin
         if (osop) begin rec_s = 0; sop_q.push_back(cyc); end
         else rec_s++;
         nvals++;
         if (oerr_flag) begin fs_q.push_back(rec_s); fv_q.push_back(int'(oerr_val)); end
         if (oeop) begin eop_q.push_back(cyc); eop_cnt = int'(oerr_cnt); eop_fail = int'(odecfail); end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick(); @(posedge iclk); #1; endtask

   task automatic clear_rec();
      sop_q.delete(); eop_q.delete(); fs_q.delete(); fv_q.delete();
      nvals = 0; eop_cnt = -1; eop_fail = -1;
   endtask

   task automatic clear_poly();
      for (int j = 0; j <= ERRS; j++) begin gL[j] = 0; gO[j] = 0; end
      gL[0] = 1;
   endtask

   task automatic drive_poly(input int deg, input bit f);
      for (int j = 0; j <= ERRS; j++) iloc_poly[j] = 8'(gL[j]);
      for (int j = 1; j <= ERRS; j++) iomega_poly[j] = 8'(gO[j]);
      iloc_poly_deg = 8'(deg);
      iloc_failed   = f;
   endtask

   task automatic send(output int a);
      a = cyc;
      iloc_poly_val = 1'b1;
      tick();
      iloc_poly_val = 1'b0;
   endtask

   task automatic wait_idle(input string nm);
      int b;
      b = 0;
      while (!ordy && b < N + 20) begin tick(); b++; end
      chk({nm, " ready"}, int'(ordy), 1);
   endtask

   // Lambda = prod(1 + X_k x), Omega = sum e_k X_k x prod_{j!=k}(1 + X_j x)
   int pos [0:ERRS-1];
   int val [0:ERRS-1];
   task automatic build_errors(input int k);
      int t [0:ERRS];
      clear_poly();
      for (int i = 0; i < k; i++) begin
         bit dup;
         do begin
            pos[i] = $urandom_range(0, N - 1);
            dup = 1'b0;
            for (int q = 0; q < i; q++) if (pos[q] == pos[i]) dup = 1'b1;
         end while (dup);
         val[i] = $urandom_range(1, 255);
      end
      for (int i = 0; i < k; i++)
         for (int j = ERRS; j >= 1; j--) gL[j] ^= gmul(gL[j-1], gexp[pos[i]]);
      for (int i = 0; i < k; i++) begin
         for (int j = 0; j <= ERRS; j++) t[j] = (j == 0) ? 1 : 0;
         for (int q = 0; q < k; q++) if (q != i)
            for (int j = ERRS; j >= 1; j--) t[j] ^= gmul(t[j-1], gexp[pos[q]]);
         for (int j = 0; j < ERRS; j++) gO[j+1] ^= gmul(gmul(val[i], gexp[pos[i]]), t[j]);
      end
   endtask

   // ---------------- test sequence ----------------
   int a, b, k, c_irr, hit, hv;
   initial begin
      begin
         int e;
         e = 1;
         glog[0] = 0;
         for (int i = 0; i < 255; i++) begin
            gexp[i] = e; glog[e] = i;
            e = e << 1;
            if ((e & 256) != 0) e ^= 285;
         end
      end
      clear_poly();
      drive_poly(0, 1'b0);
      tick();
      chk_en = 1'b1;
      chk("reset ordy", int'(ordy), 1);
      chk("reset oval", int'(oval), 0);
      chk("reset others", int'({osop, oeop, oerr_flag, oerr_val, oerr_cnt, odecfail}), 0);
      tick(); tick();
      ireset = 1'b0;
      tick();

      // no errors
      clear_poly(); drive_poly(0, 1'b0); clear_rec();
      send(a); wait_idle("t1");
      chk("t1 nvals", nvals, 255);
      chk("t1 sop cyc", sop_q.size() > 0 ? sop_q[0] : -1, a + 3);
      chk("t1 eop cyc", eop_q.size() > 0 ? eop_q[0] : -1, a + 257);
      chk("t1 flags", fs_q.size(), 0);
      chk("t1 cnt", eop_cnt, 0);
      chk("t1 decfail", eop_fail, 0);

      // single error p=10, e=0x5A
      clear_poly(); gL[1] = gexp[10]; gO[1] = gmul(8'h5A, gexp[10]);
      drive_poly(1, 1'b0); clear_rec();
      send(a);
      chk("t2 model flag", int'(ef[244]), 1);
      chk("t2 model val", ev[244], FEN ? 8'h5A : 0);
      wait_idle("t2");
      chk("t2 nflags", fs_q.size(), 1);
      chk("t2 flag s", fs_q.size() > 0 ? fs_q[0] : -1, 244);
      chk("t2 flag val", fv_q.size() > 0 ? fv_q[0] : -1, FEN ? 8'h5A : 0);
      chk("t2 cnt", eop_cnt, 1);
      chk("t2 decfail", eop_fail, 0);

      // random error patterns, first one with the full 8
      for (int r = 0; r < 6; r++) begin
         k = (r == 0) ? ERRS : $urandom_range(1, ERRS);
         build_errors(k); drive_poly(k, 1'b0); clear_rec();
         send(a); wait_idle("t3");
         chk("t3 nflags", fs_q.size(), k);
         chk("t3 cnt", eop_cnt, k);
         chk("t3 decfail", eop_fail, 0);
         for (int i = 0; i < k; i++) begin
            hit = 0; hv = -1;
            foreach (fs_q[q]) if (fs_q[q] == N - 1 - pos[i]) begin hit = 1; hv = fv_q[q]; end
            chk("t3 pos found", hit, 1);
            chk("t3 pos val", hv, FEN ? val[i] : 0);
         end
      end
      // same roots but upstream failure: flags forced off
      drive_poly(k, 1'b1); clear_rec();
      send(a); wait_idle("t3f");
      chk("t3f flags", fs_q.size(), 0);
      chk("t3f decfail", eop_fail, 1);

      // irreducible quadratic 1 + x + c x^2
      c_irr = 0;
      for (int c = 1; c < 256 && c_irr == 0; c++) begin
         bit any;
         any = 1'b0;
         for (int x = 1; x < 256; x++) if ((1 ^ x ^ gmul(c, gmul(x, x))) == 0) any = 1'b1;
         if (!any) c_irr = c;
      end
      clear_poly(); gL[1] = 1; gL[2] = c_irr;
      drive_poly(2, 1'b0); clear_rec();
      send(a); wait_idle("t4");
      chk("t4 flags", fs_q.size(), 0);
      chk("t4 cnt", eop_cnt, 0);
      chk("t4 decfail", eop_fail, 1);
      drive_poly(2, 1'b1); clear_rec();
      send(a); wait_idle("t4f");
      chk("t4f flags", fs_q.size(), 0);
      chk("t4f decfail", eop_fail, 1);

      // busy strobe ignored, back-to-back strobe accepted
      clear_poly(); gL[1] = gexp[10]; gO[1] = gmul(8'h5A, gexp[10]);
      drive_poly(1, 1'b0); clear_rec();
      send(a);
      while (cyc < a + 5) tick();
      gL[1] = gexp[3]; gO[1] = gmul(8'h21, gexp[3]);
      drive_poly(1, 1'b1);
      iloc_poly_val = 1'b1; tick(); iloc_poly_val = 1'b0;
      drive_poly(1, 1'b0);
      while (cyc < a + N + 3) tick();
      chk("t5 ordy at A+n+3", int'(ordy), 1);
      send(b);
      wait_idle("t5");
      chk("t5 nsop", sop_q.size(), 2);
      chk("t5 second sop", sop_q.size() > 1 ? sop_q[1] : -1, a + N + 6);
      chk("t5 neop", eop_q.size(), 2);
      chk("t5 nvals", nvals, 2 * N);
      chk("t5 nflags", fs_q.size(), 2);
      chk("t5 second flag s", fs_q.size() > 1 ? fs_q[1] : -1, 251);

      // reset mid-frame, then a fresh bundle
      clear_poly(); gL[1] = gexp[10]; gO[1] = gmul(8'h5A, gexp[10]);
      drive_poly(1, 1'b0); clear_rec();
      send(a);
      while (cyc < a + 100) tick();
      ireset = 1'b1; tick(); ireset = 1'b0;
      chk("t6 ordy after reset", int'(ordy), 1);
      chk("t6 oval after reset", int'(oval), 0);
      send(b);
      wait_idle("t6");
      chk("t6 neop", eop_q.size(), 1);
      chk("t6 eop cyc", eop_q.size() > 0 ? eop_q[0] : -1, b + N + 2);
      chk("t6 nvals", nvals, 98 + N);
      chk("t6 nflags", fs_q.size(), 1);
      tick(); tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
